mxint_cast: RTL and testbench

MXINT_CAST -- requirements
Module: mxint_cast

---
 rtl/mxint_cast_if.sv | 60 ++++++
 rtl/mxint_cast.sv | 154 +++++++++++++++
 tb/tb_mxint_cast.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mxint_cast_if.sv
// ---------------------------------------------------------------------------
// mxint_cast_if
// Bundles the block-floating-point stream that enters and leaves mxint_cast.
// The upstream side carries wide mantissas plus one shared exponent, and the
// downstream side carries narrowed mantissas plus the adjusted exponent.
// Each side uses a valid/ready handshake.
//
// Signals:
//   mdata_in_0        BLOCK_SIZE x IN_MAN_WIDTH   wide two's-complement mantissas
//   edata_in_0        IN_EXP_WIDTH                shared input exponent
//   data_in_0_valid   1                           input block valid
//   data_in_0_ready   1                           block can accept input
//   mdata_out_0       BLOCK_SIZE x OUT_MAN_WIDTH  narrowed mantissas
//   edata_out_0       IN_EXP_WIDTH                adjusted shared exponent
//   data_out_0_valid  1                           output block valid
//   data_out_0_ready  1                           downstream accepts
//
// Modports:
//   slave   the cast block's view (consumes the input, produces the output)
//   master  the environment's view (produces the input, consumes the output)
// ---------------------------------------------------------------------------
interface mxint_cast_if #(
  parameter int IN_MAN_WIDTH  = 11,
  parameter int IN_EXP_WIDTH  = 8,
  parameter int OUT_MAN_WIDTH = 4,
  parameter int BLOCK_SIZE    = 2
);

  logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0]  mdata_in_0;
  logic [IN_EXP_WIDTH-1:0]                  edata_in_0;
  logic                                     data_in_0_valid;
  logic                                     data_in_0_ready;
  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] mdata_out_0;
  logic [IN_EXP_WIDTH-1:0]                  edata_out_0;
  logic                                     data_out_0_valid;
  logic                                     data_out_0_ready;

  modport slave (
    input  mdata_in_0,
    input  edata_in_0,
    input  data_in_0_valid,
    output data_in_0_ready,
    output mdata_out_0,
    output edata_out_0,
    output data_out_0_valid,
    input  data_out_0_ready
  );

  modport master (
    output mdata_in_0,
    output edata_in_0,
    output data_in_0_valid,
    input  data_in_0_ready,
    input  mdata_out_0,
    input  edata_out_0,
    input  data_out_0_valid,
    output data_out_0_ready
  );

endinterface

// File: rtl/mxint_cast.sv
// ---------------------------------------------------------------------------
// mxint_cast
// Narrows a block of wide two's-complement mantissas that share one exponent
// down to OUT_MAN_WIDTH bits. The mantissas are shifted right just far enough
// that the widest one fits. That shift is added to the shared exponent. When
// the exponent would exceed its largest positive value, the exponent is
// clamped and every nonzero mantissa is driven to full scale with its sign.
//
// The block is a two-stage valid/ready pipeline:
//   stage 1 holds the input block and the required shift,
//   stage 2 holds the shifted mantissas and the adjusted exponent.
//
// Ports:
//   clk  input   rising-edge clock
//   rst  input   synchronous active-high reset; clears both stages
//   bus  slave   mxint_cast_if stream (input block in, narrowed block out)
// ---------------------------------------------------------------------------
module mxint_cast #(
  parameter int IN_MAN_WIDTH  = 11,
  parameter int IN_EXP_WIDTH  = 8,
  parameter int OUT_MAN_WIDTH = 4,
  parameter int BLOCK_SIZE    = 2
) (
  input  logic        clk,
  input  logic        rst,
  mxint_cast_if.slave bus
);

  // Wide enough for any mantissa width 1..IN_MAN_WIDTH and for any shift.
  localparam int SHIFT_WIDTH = $clog2(IN_MAN_WIDTH + 1);
  localparam int EXP_SUM_W   = IN_EXP_WIDTH + 1;

  localparam logic [SHIFT_WIDTH-1:0]       OUT_W     = SHIFT_WIDTH'(OUT_MAN_WIDTH);
  localparam logic signed [EXP_SUM_W-1:0]  EXP_MAX   = EXP_SUM_W'((1 << (IN_EXP_WIDTH - 1)) - 1);
  localparam logic [IN_EXP_WIDTH-1:0]      EXP_SAT   = IN_EXP_WIDTH'((1 << (IN_EXP_WIDTH - 1)) - 1);
  localparam logic [OUT_MAN_WIDTH-1:0]     MAN_MAX   = {1'b0, {(OUT_MAN_WIDTH - 1){1'b1}}};
  localparam logic [OUT_MAN_WIDTH-1:0]     MAN_MIN   = {1'b1, {(OUT_MAN_WIDTH - 1){1'b0}}};

  // Stage 1 registers
  logic                                     r_s1Valid;
  logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0]  r_s1Man;
  logic [IN_EXP_WIDTH-1:0]                  r_s1Exp;
  logic [SHIFT_WIDTH-1:0]                   r_s1Shift;

  // Stage 2 (output) registers
  logic                                     r_s2Valid;
  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] r_outMan;
  logic [IN_EXP_WIDTH-1:0]                  r_outExp;

  // Combinational helpers
  logic                                     w_s1Ready;
  logic                                     w_s2Ready;
  logic [SHIFT_WIDTH-1:0]                   w_maxWidth;
  logic [SHIFT_WIDTH-1:0]                   w_shift;
  logic signed [EXP_SUM_W-1:0]              w_expSum;
  logic                                     w_overflow;
  logic signed [IN_MAN_WIDTH-1:0]           w_shiftFull [BLOCK_SIZE];
  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] w_manOut;
  logic [IN_EXP_WIDTH-1:0]                  w_expOut;

  // Smallest two's-complement width that holds v. Negative values are
  // folded onto their one's complement so that the answer is one more than
  // the index of the highest bit that differs from the sign.
  function automatic logic [SHIFT_WIDTH-1:0] minWidth(input logic [IN_MAN_WIDTH-1:0] v);
    logic [IN_MAN_WIDTH-1:0] u;
    logic [SHIFT_WIDTH-1:0]  w;
    u = v[IN_MAN_WIDTH-1] ? ~v : v;
    w = SHIFT_WIDTH'(1);
    for (int b = 0; b < IN_MAN_WIDTH; b++) begin
      if (u[b]) w = SHIFT_WIDTH'(b + 2);
    end
    return w;
  endfunction

  // Stage 2 takes a new block when it is empty or its block leaves this cycle.
  // Stage 1 takes a new block when it is empty or its block moves into stage 2.
  // The ready output never looks at data_in_0_valid, and it is forced low
  // during reset.
  assign w_s2Ready           = !r_s2Valid || bus.data_out_0_ready;
  assign w_s1Ready           = !r_s1Valid || w_s2Ready;
  assign bus.data_in_0_ready = !rst && w_s1Ready;

  // The shift is the amount by which the widest mantissa in the block
  // overshoots the output width. It is zero if every mantissa already fits.
  always_comb begin
    w_maxWidth = SHIFT_WIDTH'(1);
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (minWidth(bus.mdata_in_0[i]) > w_maxWidth) w_maxWidth = minWidth(bus.mdata_in_0[i]);
    end
    w_shift = (w_maxWidth > OUT_W) ? (w_maxWidth - OUT_W) : '0;
  end

  // The exponent is widened by one bit so that an overflow past the largest
  // positive exponent can be seen. On overflow the exponent is clamped, and
  // nonzero mantissas go to full scale with their own sign, because their
  // true magnitude cannot be represented.
  always_comb begin
    w_expSum   = EXP_SUM_W'($signed(r_s1Exp)) + EXP_SUM_W'(r_s1Shift);
    w_overflow = (w_expSum > EXP_MAX);
    w_expOut   = w_overflow ? EXP_SAT : w_expSum[IN_EXP_WIDTH-1:0];
    w_manOut   = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      w_shiftFull[i] = $signed(r_s1Man[i]) >>> r_s1Shift;
      if (!w_overflow) begin
        w_manOut[i] = w_shiftFull[i][OUT_MAN_WIDTH-1:0];
      end else if (r_s1Man[i] == '0) begin
        w_manOut[i] = '0;
      end else if (r_s1Man[i][IN_MAN_WIDTH-1]) begin
        w_manOut[i] = MAN_MIN;
      end else begin
        w_manOut[i] = MAN_MAX;
      end
    end
  end

  // Stage 1 captures the raw block together with its shift. It keeps its
  // contents while stage 2 is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Man   <= '0;
      r_s1Exp   <= '0;
      r_s1Shift <= '0;
    end else if (w_s1Ready) begin
      r_s1Valid <= bus.data_in_0_valid;
      if (bus.data_in_0_valid) begin
        r_s1Man   <= bus.mdata_in_0;
        r_s1Exp   <= bus.edata_in_0;
        r_s1Shift <= w_shift;
      end
    end
  end

  // Stage 2 holds the finished block. It only changes when it is empty or
  // downstream accepts, so the outputs stay still under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
      r_outMan  <= '0;
      r_outExp  <= '0;
    end else if (w_s2Ready) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outMan <= w_manOut;
        r_outExp <= w_expOut;
      end
    end
  end

  assign bus.mdata_out_0      = r_outMan;
  assign bus.edata_out_0      = r_outExp;
  assign bus.data_out_0_valid = r_s2Valid;

endmodule

// File: tb/tb_mxint_cast.sv
// ---------------------------------------------------------------------------
// tb_mxint_cast
// Directed bench for mxint_cast at its default sizes (11-bit mantissas in,
// 4-bit mantissas out, 8-bit exponent, blocks of two). Expected values are
// either worked out by hand or taken from a small integer model of the
// narrowing rule.
// ---------------------------------------------------------------------------
module tb_mxint_cast;

  localparam int IMW = 11;
  localparam int IEW = 8;
  localparam int OMW = 4;
  localparam int BS  = 2;

  typedef struct {
    int m0;
    int m1;
    int e;
  } blk_t;

  typedef struct {
    logic [7:0] man;
    logic [7:0] exp;
  } res_t;

  logic clk;
  logic rst;

  int   nCompared;
  int   nMismatched;
  blk_t srcQ[$];
  res_t expQ[$];

  mxint_cast_if #(
    .IN_MAN_WIDTH (IMW),
    .IN_EXP_WIDTH (IEW),
    .OUT_MAN_WIDTH(OMW),
    .BLOCK_SIZE   (BS)
  ) bus ();

  mxint_cast #(
    .IN_MAN_WIDTH (IMW),
    .IN_EXP_WIDTH (IEW),
    .OUT_MAN_WIDTH(OMW),
    .BLOCK_SIZE   (BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Smallest signed width that holds v, found by testing value ranges.
  function automatic int minW(input int v);
    for (int w = 1; w < 32; w++) begin
      if (v >= -(1 <<< (w - 1)) && v < (1 <<< (w - 1))) return w;
    end
    return 32;
  endfunction

  // Reference result for one block.
  function automatic res_t model(input blk_t b);
    res_t r;
    int   v[2];
    int   o[2];
    int   wMax;
    int   s;
    int   e;
    v[0] = b.m0;
    v[1] = b.m1;
    wMax = (minW(v[0]) > minW(v[1])) ? minW(v[0]) : minW(v[1]);
    s    = (wMax > OMW) ? wMax - OMW : 0;
    e    = b.e + s;
    for (int i = 0; i < 2; i++) begin
      if (e > 127) o[i] = (v[i] == 0) ? 0 : ((v[i] > 0) ? 7 : -8);
      else         o[i] = v[i] >>> s;
    end
    if (e > 127) e = 127;
    r.man = {o[1][3:0], o[0][3:0]};
    r.exp = e[7:0];
    return r;
  endfunction

  // Places a block (or an idle cycle) on the input side.
  task automatic applyStimulus(input logic v, input int m0, input int m1, input int e);
    bus.mdata_in_0      = {11'(m1), 11'(m0)};
    bus.edata_in_0      = 8'(e);
    bus.data_in_0_valid = v;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends one block into an empty pipeline. It checks that the output is
  // still idle one cycle after the handshake, that the result appears two
  // cycles after it, and that the result is emitted only once.
  task automatic sendAndExpect(input string tag, input int m0, input int m1, input int e,
                               input logic [7:0] expMan, input logic [7:0] expExp);
    @(negedge clk);
    applyStimulus(1'b1, m0, m1, e);
    bus.data_out_0_ready = 1'b1;
    #1 checkOutput({tag, "_in_ready"}, 32'(bus.data_in_0_ready), 32'd1);
    @(posedge clk);
    #1 applyStimulus(1'b0, 0, 0, 0);
    checkOutput({tag, "_lat1_valid"}, 32'(bus.data_out_0_valid), 32'd0);
    @(posedge clk);
    #1 checkOutput({tag, "_lat2_valid"}, 32'(bus.data_out_0_valid), 32'd1);
    checkOutput({tag, "_man"}, 32'(bus.mdata_out_0), 32'(expMan));
    checkOutput({tag, "_exp"}, 32'(bus.edata_out_0), 32'(expExp));
    @(posedge clk);
    #1 checkOutput({tag, "_no_dup"}, 32'(bus.data_out_0_valid), 32'd0);
  endtask

  // Feeds srcQ into the DUT and checks every emitted block against expQ.
  // Valid and ready are drawn at the given percentages, and an offered block
  // stays on the bus until it is accepted.
  task automatic runStream(input string tag, input int maxCycles, input int validPct, input int readyPct);
    int   cyc;
    bit   presenting;
    res_t r;
    cyc        = 0;
    presenting = 1'b0;
    while ((srcQ.size() > 0 || expQ.size() > 0) && cyc < maxCycles) begin
      @(negedge clk);
      if (srcQ.size() > 0 && (presenting || $urandom_range(99) < validPct)) begin
        applyStimulus(1'b1, srcQ[0].m0, srcQ[0].m1, srcQ[0].e);
        presenting = 1'b1;
      end else begin
        applyStimulus(1'b0, 0, 0, 0);
      end
      bus.data_out_0_ready = ($urandom_range(99) < readyPct);
      #1;
      if (bus.data_out_0_valid && bus.data_out_0_ready) begin
        if (expQ.size() == 0) begin
          checkOutput({tag, "_extra_block"}, 32'd1, 32'd0);
        end else begin
          r = expQ.pop_front();
          checkOutput({tag, "_man"}, 32'(bus.mdata_out_0), 32'(r.man));
          checkOutput({tag, "_exp"}, 32'(bus.edata_out_0), 32'(r.exp));
        end
      end
      if (bus.data_in_0_valid && bus.data_in_0_ready) begin
        expQ.push_back(model(srcQ.pop_front()));
        presenting = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    checkOutput({tag, "_all_drained"}, 32'(srcQ.size() + expQ.size()), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 0);
    bus.data_out_0_ready = 1'b1;
  endtask

  // Directed sequence
  initial begin
    blk_t b;
    int   seen;
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b1;
    applyStimulus(1'b0, 0, 0, 0);
    bus.data_out_0_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 checkOutput("rst_out_valid", 32'(bus.data_out_0_valid), 32'd0);
    checkOutput("rst_man", 32'(bus.mdata_out_0), 32'd0);
    checkOutput("rst_exp", 32'(bus.edata_out_0), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.data_in_0_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post_rst_in_ready", 32'(bus.data_in_0_ready), 32'd1);

    // Narrowing, passthrough, zero block, saturation
    sendAndExpect("narrow", 100, -3, 5, 8'hF6, 8'h09);
    sendAndExpect("pass", 7, -8, -2, 8'h87, 8'hFE);
    sendAndExpect("zero", 0, 0, 3, 8'h00, 8'h03);
    sendAndExpect("sat_pos", 100, 0, 126, 8'h07, 8'h7F);
    sendAndExpect("sat_neg", -100, 5, 127, 8'h78, 8'h7F);

    // Backpressure: downstream stalls while blocks A and B fill both stages
    @(negedge clk);
    bus.data_out_0_ready = 1'b0;
    applyStimulus(1'b1, 100, -3, 5);
    #1 checkOutput("bp_in_ready_a", 32'(bus.data_in_0_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 7, -8, -2);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, -100, 5, 127);
    #1 checkOutput("bp_full_valid", 32'(bus.data_out_0_valid), 32'd1);
    checkOutput("bp_full_man", 32'(bus.mdata_out_0), 32'hF6);
    checkOutput("bp_full_exp", 32'(bus.edata_out_0), 32'h09);
    checkOutput("bp_full_in_ready", 32'(bus.data_in_0_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 checkOutput("bp_hold_valid", 32'(bus.data_out_0_valid), 32'd1);
    checkOutput("bp_hold_man", 32'(bus.mdata_out_0), 32'hF6);
    checkOutput("bp_hold_exp", 32'(bus.edata_out_0), 32'h09);
    checkOutput("bp_hold_in_ready", 32'(bus.data_in_0_ready), 32'd0);
    @(posedge clk);
    b = '{100, -3, 5};
    expQ.push_back(model(b));
    b = '{7, -8, -2};
    expQ.push_back(model(b));
    srcQ.push_back('{-100, 5, 127});
    srcQ.push_back('{50, -60, 0});
    runStream("bp_drain", 40, 100, 100);

    // Mid-stream reset with two blocks in flight
    @(negedge clk);
    bus.data_out_0_ready = 1'b0;
    applyStimulus(1'b1, 300, 1, 0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, -200, 2, 1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 checkOutput("mid_rst_valid", 32'(bus.data_out_0_valid), 32'd0);
    checkOutput("mid_rst_man", 32'(bus.mdata_out_0), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(bus.data_in_0_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.data_out_0_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (bus.data_out_0_valid) seen++;
    end
    checkOutput("mid_rst_no_emit", 32'(seen), 32'd0);
    sendAndExpect("post_rst", -50, 20, -10, 8'h29, 8'hF9);

    // Random blocks under random valid/ready
    for (int n = 0; n < 1000; n++) begin
      int w0;
      int w1;
      w0 = $urandom_range(11, 1);
      w1 = $urandom_range(11, 1);
      b.m0 = int'($urandom_range((1 << w0) - 1)) - (1 << (w0 - 1));
      b.m1 = int'($urandom_range((1 << w1) - 1)) - (1 << (w1 - 1));
      if ($urandom_range(3) == 0) b.e = int'($urandom_range(127, 115));
      else                        b.e = int'($urandom_range(255)) - 128;
      srcQ.push_back(b);
    end
    runStream("rand", 20000, 70, 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
